// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU share arbiter: ALU control codes and the
// width of the optional statistics counters (ALU_ARB_STATS_EN).
package alu_arb_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_BEQ  = 4'b1001;
    localparam logic [3:0] ALU_BNE  = 4'b1010;
    localparam logic [3:0] ALU_BLT  = 4'b1011;
    localparam logic [3:0] ALU_BGE  = 4'b1100;
    localparam logic [3:0] ALU_BGT  = 4'b1110;

    // Width of each saturating statistics counter.
    localparam int STATS_W = 16;

    // Index width for a requester population (at least one bit).
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_picker.sv
// Round-robin picker: finds the first set request at or after ptr_i, with
// wrap-around. Purely combinational; the pointer is owned by the caller.
module rr_picker
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int ID_W   = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    // Scan offsets from farthest to nearest so the nearest hit wins last.
    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = ID_W'(j);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// The granted operands drive the ALU in the same cycle; the result is captured
// into a one-entry buffer returned under valid/ready.
// Optional feature: define ALU_ARB_STATS_EN to add per-requester grant counters
// and a stall counter (saturating).
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32,
    localparam int ID_W   = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0][3:0]       req_ctl,
    input  logic [NUM_REQ-1:0][XLEN-1:0]  req_a,
    input  logic [NUM_REQ-1:0][XLEN-1:0]  req_b,
    output logic [3:0]                    alu_ctl,
    output logic [XLEN-1:0]               alu_a,
    output logic [XLEN-1:0]               alu_b,
    input  logic [XLEN-1:0]               alu_out,
    input  logic                          alu_zero,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [XLEN-1:0]               rsp_result,
    output logic                          rsp_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][STATS_W-1:0] grant_cnt,
    output logic [STATS_W-1:0]              stall_cnt
`endif
);

    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [XLEN-1:0]    rsp_result_q, rsp_result_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic               can_issue;
    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;

    // The buffer can take a new result when empty or draining this cycle.
    assign can_issue = !rsp_valid_q || rsp_ready;
    // Masking with rst_n keeps req_ready and the ALU mux quiet during reset.
    assign pick_req  = req_valid & {NUM_REQ{can_issue && rst_n}};

    rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i (pick_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt_oh),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign req_ready = gnt_oh;

    // Drive the granted slice onto the ALU; zeros (ADD 0,0) when idle.
    always_comb begin
        alu_ctl = '0;
        alu_a   = '0;
        alu_b   = '0;
        if (gnt_any) begin
            alu_ctl = req_ctl[gnt_idx];
            alu_a   = req_a[gnt_idx];
            alu_b   = req_b[gnt_idx];
        end
    end

    // Buffer next state: load on transfer, clear on drain, else hold.
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rr_ptr_d     = rr_ptr_q;
        if (gnt_any) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = gnt_idx;
            rsp_result_d = alu_out;
            rsp_zero_d   = alu_zero;
            rr_ptr_d     = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    // Buffer and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rr_ptr_q     <= '0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;

`ifdef ALU_ARB_STATS_EN
    logic [NUM_REQ-1:0][STATS_W-1:0] grant_cnt_q, grant_cnt_d;
    logic [STATS_W-1:0]              stall_cnt_q, stall_cnt_d;

    // Saturating counters: transfers per requester, and blocked-request cycles.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        stall_cnt_d = stall_cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_oh[i] && grant_cnt_q[i] != '1) grant_cnt_d[i] = grant_cnt_q[i] + 1'b1;
        end
        if (|req_valid && !can_issue && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
